acoustic_event_reporter: RTL and testbench

- Parametrised successor to the fixed two-channel "trigger, capture, send offset byte" path.
- Accepts CH filtered ADC channels, arms after a holdoff, and triggers when any channel exceeds a runtime threshold.
- Over a capture window it tracks each channel's peak value and the sample index of that peak.
- It then sends one checksummed multi-byte frame over 8N1 UART, driven from the single system clock through a baud divider.

---
 rtl/acoustic_pkg.sv | 24 ++
 rtl/acoustic_event_reporter_uart.sv | 84 ++++++++
 rtl/acoustic_event_reporter.sv | 221 ++++++++++++++++++++++
 tb/tb_acoustic_event_reporter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acoustic_pkg.sv
// Shared types and constants for the acoustic event reporter.
//   state_t         : top-level sequencing states
//   START_BIT/STOP_BIT : UART line levels for framing bits
//   BITS_PER_BYTE   : start + 8 data + stop
//   frame_len(ch)   : bytes in one report frame for ch channels
package acoustic_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      REPORT  = 2'd3
   } state_t;

   localparam logic START_BIT     = 1'b0;
   localparam logic STOP_BIT      = 1'b1;
   localparam int   BITS_PER_BYTE = 10;

   // sync + trigger mask + 4 bytes per channel + checksum
   function automatic int frame_len(input int ch);
      return 3 + 4 * ch;
   endfunction

endpackage

// File: rtl/acoustic_event_reporter_uart.sv
// 8N1 UART byte transmitter driven from the system clock.
//   clk, rst : system clock, asynchronous active-high reset
//   start    : launch a byte; only honoured while ready is high
//   data     : byte to send, captured on an accepted start
//   tx       : serial line, idle high
//   ready    : high when idle and during the final clock of a stop bit
// Handshake: a byte is taken on any cycle where start && ready. Because
// ready is already high in the last stop-bit clock, a start there begins
// the next start bit on the following clock, giving gapless bytes.
module uart_tx_byte
   import acoustic_pkg::*;
#(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int CNT_W = $clog2(BAUD_DIV);

   logic             active_q, active_d;
   logic             tx_q, tx_d;
   logic [8:0]       shift_q, shift_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [3:0]       bit_q, bit_d;
   logic             bit_end, byte_end;

   assign bit_end  = active_q && (baud_q == CNT_W'(BAUD_DIV - 1));
   assign byte_end = bit_end && (bit_q == 4'(BITS_PER_BYTE - 1));
   assign ready    = !active_q || byte_end;
   assign tx       = tx_q;

   always_comb begin
      active_d = active_q;
      tx_d     = tx_q;
      shift_d  = shift_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      if (active_q) begin
         if (bit_end) begin
            baud_d = '0;
            if (byte_end) begin
               active_d = 1'b0;
               tx_d     = STOP_BIT;
            end else begin
               // shift_q holds the remaining data bits with the stop bit on top
               bit_d   = bit_q + 4'd1;
               tx_d    = shift_q[0];
               shift_d = {STOP_BIT, shift_q[8:1]};
            end
         end else begin
            baud_d = baud_q + CNT_W'(1);
         end
      end
      if (start && ready) begin
         active_d = 1'b1;
         tx_d     = START_BIT;
         shift_d  = {STOP_BIT, data};
         baud_d   = '0;
         bit_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         tx_q     <= STOP_BIT;
         shift_q  <= '1;
         baud_q   <= '0;
         bit_q    <= '0;
      end else begin
         active_q <= active_d;
         tx_q     <= tx_d;
         shift_q  <= shift_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
      end
   end

endmodule

// File: rtl/acoustic_event_reporter.sv
// Multi-channel acoustic event reporter: after a holdoff it arms, triggers
// when any channel exceeds a signed threshold, tracks per-channel peak value
// and index over a capture window, then sends a checksummed UART frame.
//   sample_valid/sample_bus : one-cycle strobe with CH packed signed samples
//   threshold               : signed trigger level
//   enable                  : gates ARMED -> CAPTURE only
//   uart_tx                 : 8N1 serial output, idle high
//   busy                    : high in CAPTURE and REPORT
//   frame_done              : one-cycle pulse after the checksum stop bit
//   trig_mask               : channels above threshold at the last trigger
// The FSM state is kept in state_q (type state_t) for observation.
module acoustic_event_reporter
   import acoustic_pkg::*;
#(
   parameter int         CH        = 2,
   parameter int         SAMPLE_W  = 12,
   parameter int         WINDOW    = 64,
   parameter int         HOLDOFF   = 625000,
   parameter int         BAUD_DIV  = 434,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sample_valid,
   input  logic [CH*SAMPLE_W-1:0] sample_bus,
   input  logic [SAMPLE_W-1:0]    threshold,
   input  logic                   enable,
   output logic                   uart_tx,
   output logic                   busy,
   output logic                   frame_done,
   output logic [CH-1:0]          trig_mask
);

   localparam int FRAME_LEN = frame_len(CH);
   localparam int IDX_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int HO_W      = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam int BI_W      = $clog2(FRAME_LEN + 1);

   state_t               state_q, state_d;
   logic [HO_W-1:0]      holdoff_q, holdoff_d;
   logic [IDX_W-1:0]     sample_cnt_q, sample_cnt_d;
   logic [BI_W-1:0]      byte_idx_q, byte_idx_d;
   logic [7:0]           csum_q, csum_d;
   logic [CH-1:0]        trig_mask_q, trig_mask_d;
   logic                 frame_done_q, frame_done_d;

   logic [CH-1:0]        above;
   logic                 load_peaks, track_peaks;
   logic signed [SAMPLE_W-1:0] threshold_s;
   logic signed [SAMPLE_W-1:0] peak_val [CH];
   logic [IDX_W-1:0]     peak_idx [CH];

   logic                 uart_start, uart_ready;
   logic [7:0]           tx_byte;
   logic [BI_W-1:0]      rel;
   logic [15:0]          sel_idx, sel_val;

   assign threshold_s = $signed(threshold);

   // Per-channel peak tracker. Strict compare keeps the earliest index on ties.
   for (genvar k = 0; k < CH; k++) begin : g_peak
      logic signed [SAMPLE_W-1:0] smp;
      logic signed [SAMPLE_W-1:0] val_q, val_d;
      logic [IDX_W-1:0]           idx_q, idx_d;

      assign smp      = $signed(sample_bus[k*SAMPLE_W +: SAMPLE_W]);
      assign above[k] = smp > threshold_s;

      always_comb begin
         val_d = val_q;
         idx_d = idx_q;
         if (load_peaks) begin
            val_d = smp;
            idx_d = '0;
         end else if (track_peaks && (smp > val_q)) begin
            val_d = smp;
            idx_d = sample_cnt_q;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            val_q <= '0;
            idx_q <= '0;
         end else begin
            val_q <= val_d;
            idx_q <= idx_d;
         end
      end

      assign peak_val[k] = val_q;
      assign peak_idx[k] = idx_q;
   end

   // Frame byte selection; peak bytes start at byte 2, four per channel.
   always_comb begin
      rel     = byte_idx_q - BI_W'(2);
      sel_idx = '0;
      sel_val = '0;
      for (int c = 0; c < CH; c++) begin
         if (rel[BI_W-1:2] == (BI_W-2)'(c)) begin
            sel_idx = 16'(peak_idx[c]);
            sel_val = 16'(peak_val[c]);   // signed source: sign-extends
         end
      end
      if (byte_idx_q == BI_W'(0)) begin
         tx_byte = SYNC_BYTE;
      end else if (byte_idx_q == BI_W'(1)) begin
         tx_byte = 8'(trig_mask_q);
      end else if (byte_idx_q == BI_W'(FRAME_LEN - 1)) begin
         tx_byte = csum_q;
      end else begin
         case (rel[1:0])
            2'd0:    tx_byte = sel_idx[15:8];
            2'd1:    tx_byte = sel_idx[7:0];
            2'd2:    tx_byte = sel_val[15:8];
            default: tx_byte = sel_val[7:0];
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      holdoff_d    = holdoff_q;
      sample_cnt_d = sample_cnt_q;
      byte_idx_d   = byte_idx_q;
      csum_d       = csum_q;
      trig_mask_d  = trig_mask_q;
      frame_done_d = 1'b0;
      load_peaks   = 1'b0;
      track_peaks  = 1'b0;
      uart_start   = 1'b0;
      case (state_q)
         HOLD: begin
            if (HOLDOFF == 0) begin
               state_d = ARMED;
            end else if (sample_valid) begin
               if (holdoff_q == HO_W'(HOLDOFF - 1)) begin
                  holdoff_d = '0;
                  state_d   = ARMED;
               end else begin
                  holdoff_d = holdoff_q + HO_W'(1);
               end
            end
         end
         ARMED: begin
            if (sample_valid && enable && (|above)) begin
               trig_mask_d  = above;
               load_peaks   = 1'b1;
               sample_cnt_d = IDX_W'(1);
               state_d      = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sample_valid) begin
               track_peaks = 1'b1;
               if (sample_cnt_q == IDX_W'(WINDOW - 1)) begin
                  sample_cnt_d = '0;
                  byte_idx_d   = '0;
                  csum_d       = '0;
                  state_d      = REPORT;
               end else begin
                  sample_cnt_d = sample_cnt_q + IDX_W'(1);
               end
            end
         end
         REPORT: begin
            // uart_ready is high when idle and in the last stop-bit clock,
            // so each new byte follows the previous one without a gap.
            if (uart_ready) begin
               if (byte_idx_q == BI_W'(FRAME_LEN)) begin
                  state_d      = HOLD;
                  frame_done_d = 1'b1;
                  holdoff_d    = '0;
               end else begin
                  uart_start = 1'b1;
                  byte_idx_d = byte_idx_q + BI_W'(1);
                  csum_d     = csum_q ^ tx_byte;
               end
            end
         end
         default: state_d = HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HOLD;
         holdoff_q    <= '0;
         sample_cnt_q <= '0;
         byte_idx_q   <= '0;
         csum_q       <= '0;
         trig_mask_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         holdoff_q    <= holdoff_d;
         sample_cnt_q <= sample_cnt_d;
         byte_idx_q   <= byte_idx_d;
         csum_q       <= csum_d;
         trig_mask_q  <= trig_mask_d;
         frame_done_q <= frame_done_d;
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_uart (
      .clk   (clk),
      .rst   (rst),
      .start (uart_start),
      .data  (tx_byte),
      .tx    (uart_tx),
      .ready (uart_ready)
   );

   assign busy       = (state_q == CAPTURE) || (state_q == REPORT);
   assign frame_done = frame_done_q;
   assign trig_mask  = trig_mask_q;

endmodule

// File: tb/tb_acoustic_event_reporter.sv
// Directed bench for acoustic_event_reporter (CH=2, WINDOW=8, HOLDOFF=4,
// BAUD_DIV=4, one sample every 3 clocks). A UART receiver decodes uart_tx
// into rx_q; expected frames are built from hand-derived peaks into exp_q.
module tb_acoustic_event_reporter;

   localparam int CH       = 2;
   localparam int SAMPLE_W = 12;
   localparam int WINDOW   = 8;
   localparam int HOLDOFF  = 4;
   localparam int BAUD_DIV = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   sample_valid;
   logic [CH*SAMPLE_W-1:0] sample_bus;
   logic [SAMPLE_W-1:0]    threshold;
   logic                   enable;
   logic                   uart_tx;
   logic                   busy;
   logic                   frame_done;
   logic [CH-1:0]          trig_mask;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         last_sv_cyc, trig_cyc, fall_cyc, done_at;
   int         stop_errs = 0;
   logic       have_fall = 1'b0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         ch0_v [8];
   int         ch1_v [8];

   acoustic_event_reporter #(
      .CH        (CH),
      .SAMPLE_W  (SAMPLE_W),
      .WINDOW    (WINDOW),
      .HOLDOFF   (HOLDOFF),
      .BAUD_DIV  (BAUD_DIV),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample_bus   (sample_bus),
      .threshold    (threshold),
      .enable       (enable),
      .uart_tx      (uart_tx),
      .busy         (busy),
      .frame_done   (frame_done),
      .trig_mask    (trig_mask)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- UART receiver (samples mid-bit on negedge) ----------------
   initial begin : rx_mon
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            if (rx_q.size() == 0 && !have_fall) begin
               fall_cyc  = cyc;
               have_fall = 1'b1;
            end
            repeat (BAUD_DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD_DIV) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (BAUD_DIV) @(negedge clk);
            if (uart_tx !== 1'b1) stop_errs++;
            rx_q.push_back(b);
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_frame(input logic [7:0] mask, input int i0, input int v0,
                               input int i1, input int v1);
      logic [15:0] t;
      logic [7:0]  cs;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(mask);
      t = 16'(i0); exp_q.push_back(t[15:8]); exp_q.push_back(t[7:0]);
      t = 16'(v0); exp_q.push_back(t[15:8]); exp_q.push_back(t[7:0]);
      t = 16'(i1); exp_q.push_back(t[15:8]); exp_q.push_back(t[7:0]);
      t = 16'(v1); exp_q.push_back(t[15:8]); exp_q.push_back(t[7:0]);
      cs = 8'h00;
      foreach (exp_q[i]) cs ^= exp_q[i];
      exp_q.push_back(cs);
   endtask

   // ---------------- drivers (called at a posedge instant) ----------------
   task automatic send_sample(input int s0, input int s1);
      #1;
      sample_bus   = {12'(s1), 12'(s0)};
      sample_valid = 1'b1;
      last_sv_cyc  = cyc;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic holdoff_phase(input int s0, input int s1);
      @(posedge clk);
      for (int i = 0; i < HOLDOFF; i++) begin
         send_sample(s0, s1);
         #2 check($sformatf("holdoff_busy%0d", i), busy, 1'b0);
      end
   endtask

   task automatic trigger(input logic [1:0] mask);
      rx_q.delete();
      have_fall = 1'b0;
      send_sample(ch0_v[0], ch1_v[0]);
      trig_cyc = last_sv_cyc;
      #2;
      check("trig_busy", busy, 1'b1);
      check("trig_mask", trig_mask, mask);
   endtask

   task automatic capture_rest(input logic [1:0] mask);
      for (int i = 1; i < WINDOW; i++) begin
         send_sample(ch0_v[i], ch1_v[i]);
         if (i == WINDOW - 2) begin
            #2;
            check("capture_busy", busy, 1'b1);
            check("tx_idle_pre", uart_tx, 1'b1);
            check("mask_held", trig_mask, mask);
         end
      end
   endtask

   task automatic wait_frame();
      int   start_cnt;
      logic seen;
      start_cnt = done_cnt;
      seen      = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != start_cnt) begin
            seen    = 1'b1;
            done_at = cyc;
         end
      end
      check("frame_done_seen", seen, 1'b1);
      check("start_latency", fall_cyc - trig_cyc, (WINDOW - 1) * 3 + 2);
      check("frame_span_clks", done_at - fall_cyc, 11 * 10 * BAUD_DIV);
      check("busy_at_done", busy, 1'b0);
      repeat (10) @(negedge clk);
      check("frame_done_once", done_cnt - start_cnt, 1);
      check("tx_idle_post", uart_tx, 1'b1);
      check("rx_count", rx_q.size(), exp_q.size());
      check("stop_bits", stop_errs, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < rx_q.size()) check($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
      end
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int done_before;
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_bus   = '0;
      threshold    = 12'd15;
      enable       = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_tx", uart_tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_mask", trig_mask, 2'b00);
      rst = 1'b0;

      // Frame 1: holdoff ignores qualifying samples; peaks with ties
      ch0_v = '{0, 5, -3, 40, 40, 2, 1, 0};
      ch1_v = '{100, 20, 300, 7, 0, 0, 0, 0};
      holdoff_phase(0, 100);
      trigger(2'b10);
      capture_rest(2'b10);
      expect_frame(8'h02, 3, 40, 2, 300);
      wait_frame();

      // Frame 2: both channels trigger, ch1 peak on the last index
      ch0_v = '{20, -5, 25, 25, 0, 0, 0, 0};
      ch1_v = '{30, 30, 30, 30, 30, 30, 30, 31};
      holdoff_phase(0, 100);
      trigger(2'b11);
      capture_rest(2'b11);
      expect_frame(8'h03, 2, 25, 7, 31);
      wait_frame();

      // Frame 3: negative channel is sign-extended, index stays 0
      ch0_v = '{-50, -50, -50, -50, -50, -50, -50, -50};
      ch1_v = '{16, 17, 17, 10, 0, 0, 0, 0};
      holdoff_phase(0, 100);
      trigger(2'b10);
      capture_rest(2'b10);
      expect_frame(8'h02, 0, -50, 1, 17);
      wait_frame();

      // Enable gating and strict threshold, then reset mid byte 5
      holdoff_phase(0, 100);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_sample(2000, 0);
         #2 check($sformatf("en0_busy%0d", i), busy, 1'b0);
      end
      enable = 1'b1;
      send_sample(15, 15);
      #2 check("thr_equal_busy", busy, 1'b0);
      ch0_v = '{2000, 0, 0, 0, 0, 0, 0, 0};
      ch1_v = '{0, 0, 0, 0, 0, 0, 0, 0};
      trigger(2'b01);
      capture_rest(2'b01);
      for (int i = 0; i < 100 && !have_fall; i++) @(negedge clk);
      check("reset_frame_started", have_fall, 1'b1);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cyc >= fall_cyc + 180) break;
      end
      done_before = done_cnt;
      #1 check("tx_low_byte5", uart_tx, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_tx", uart_tx, 1'b1);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_mask", trig_mask, 2'b00);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (60) @(posedge clk);
      check("no_done_after_rst", done_cnt - done_before, 0);
      rx_q.delete();
      have_fall = 1'b0;

      // Frame 5: holdoff re-observed after reset, then a full frame
      ch0_v = '{2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000};
      ch1_v = '{0, 0, 0, 0, 0, 0, 0, 0};
      holdoff_phase(2000, 0);
      trigger(2'b01);
      capture_rest(2'b01);
      expect_frame(8'h01, 0, 2000, 0, 0);
      wait_frame();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
